// File: rtl/sig_pkg.sv
// Shared lamp and scheduler-state encodings for the
// country-road request scheduler.
package sig_pkg;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_GRN = 3'b010;
  localparam logic [2:0] LAMP_YEL = 3'b001;

  typedef enum logic [1:0] {
    S_HWY   = 2'd0,
    S_REQ   = 2'd1,
    S_CNTRY = 2'd2,
    S_REL   = 2'd3
  } state_t;

  // Both lamp heads dark means the controller is held in reset.
  function automatic logic lamps_dark(
    input logic [2:0] hwy,
    input logic [2:0] cntry
  );
    return (hwy == LAMP_OFF) && (cntry == LAMP_OFF);
  endfunction

endpackage

// File: rtl/cntry_req_sched_if.sv
// Signal bundle between the request scheduler and its
// surroundings (sensors, buttons, signal controller).
interface cntry_req_sched_if;

  logic       car_raw;
  logic       ped_btn;
  logic [2:0] rgb_hwy;
  logic [2:0] rgb_cntry;
  logic       X;
  logic       ped_pending;
  logic       car_deb;

  modport master (
    output car_raw,
    output ped_btn,
    output rgb_hwy,
    output rgb_cntry,
    input  X,
    input  ped_pending,
    input  car_deb
  );

  modport slave (
    input  car_raw,
    input  ped_btn,
    input  rgb_hwy,
    input  rgb_cntry,
    output X,
    output ped_pending,
    output car_deb
  );

endinterface

// File: rtl/sig_debounce.sv
// Two-flop synchroniser followed by a stability counter:
// dout follows din only after DEB_CYC equal samples.
module sig_debounce #(
  parameter int W_CNT   = 8,
  parameter int DEB_CYC = 16
) (
  input  logic clock,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic             s1;
  logic             s2;
  logic [W_CNT-1:0] cnt;

  // Synchronise, then count consecutive samples that
  // disagree with dout; any agreeing sample restarts.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == W_CNT'(DEB_CYC - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + W_CNT'(1);
      end
    end
  end

endmodule

// File: rtl/cntry_req_sched.sv
// Country-road request scheduler: debounces the car sensor,
// latches pedestrian requests and paces X against the lamps.
module cntry_req_sched
  import sig_pkg::*;
#(
  parameter int CW        = 29,
  parameter int DEB_CYC   = 16,
  parameter int HWY_MIN   = 1000,
  parameter int CNTRY_MIN = 200,
  parameter int CNTRY_MAX = 5000
) (
  input logic              clock,
  input logic              rst_n,
  cntry_req_sched_if.slave bus
);

  localparam logic [CW-1:0] HWY_LIM = CW'(HWY_MIN);
  localparam logic [CW-1:0] CMIN    = CW'(CNTRY_MIN);
  localparam logic [CW-1:0] CMAX    = CW'(CNTRY_MAX);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state;
  state_t        nxt;
  logic          x_d;
  logic          x_q;
  logic [CW-1:0] hwy_t;
  logic [CW-1:0] cntry_t;
  logic          car_q;
  logic          ped_q;
  logic          p_s1;
  logic          p_s2;
  logic          p_s3;
  logic          ped_edge;
  logic          demand;
  logic          dark;
  logic          hwy_grn;
  logic          cntry_grn;
  logic          enter_cntry;
  logic          enter_hwy;

  sig_debounce #(
    .W_CNT   (CW),
    .DEB_CYC (DEB_CYC)
  ) u_car_deb (
    .clock (clock),
    .rst_n (rst_n),
    .din   (bus.car_raw),
    .dout  (car_q)
  );

  assign dark        = lamps_dark(bus.rgb_hwy, bus.rgb_cntry);
  assign hwy_grn     = (bus.rgb_hwy == LAMP_GRN);
  assign cntry_grn   = (bus.rgb_cntry == LAMP_GRN);
  assign ped_edge    = p_s2 & ~p_s3;
  assign demand      = car_q | ped_q;
  assign enter_cntry = (state == S_REQ) && (nxt == S_CNTRY);
  assign enter_hwy   = (state == S_REL) && (nxt == S_HWY);

  // State register; X is registered from the next state.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state <= S_HWY;
      x_q   <= 1'b0;
    end else begin
      state <= nxt;
      x_q   <= x_d;
    end
  end

  // Next-state logic driven by demand, timers and lamps.
  always_comb begin
    nxt = state;
    unique case (state)
      S_HWY: begin
        if (!dark && demand && (hwy_t >= HWY_LIM))
          nxt = S_REQ;
      end
      S_REQ: begin
        if (cntry_grn)
          nxt = S_CNTRY;
      end
      S_CNTRY: begin
        if ((cntry_t >= CMAX) ||
            (!car_q && (cntry_t >= CMIN)))
          nxt = S_REL;
      end
      S_REL: begin
        if (hwy_grn)
          nxt = S_HWY;
      end
      default: nxt = S_HWY;
    endcase
  end

  // X is asserted while requesting or holding the country road.
  always_comb begin
    x_d = 1'b0;
    unique case (nxt)
      S_REQ:   x_d = 1'b1;
      S_CNTRY: x_d = 1'b1;
      default: x_d = 1'b0;
    endcase
  end

  // Highway and country green timers, both saturating.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      hwy_t   <= '0;
      cntry_t <= '0;
    end else begin
      if (enter_hwy)
        hwy_t <= '0;
      else if ((state == S_HWY) && hwy_grn && (hwy_t != '1))
        hwy_t <= hwy_t + ONE;
      if (enter_cntry)
        cntry_t <= '0;
      else if ((state == S_CNTRY) && !dark && (cntry_t != '1))
        cntry_t <= cntry_t + ONE;
    end
  end

  // Pedestrian sync/edge detect; requests seen during the
  // country phase are already being served.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      p_s1  <= 1'b0;
      p_s2  <= 1'b0;
      p_s3  <= 1'b0;
      ped_q <= 1'b0;
    end else begin
      p_s1 <= bus.ped_btn;
      p_s2 <= p_s1;
      p_s3 <= p_s2;
      if (enter_cntry)
        ped_q <= 1'b0;
      else if (ped_edge && (state != S_CNTRY))
        ped_q <= 1'b1;
    end
  end

  assign bus.X           = x_q;
  assign bus.ped_pending = ped_q;
  assign bus.car_deb     = car_q;

endmodule

// File: tb/tb_cntry_req_sched.sv
// Directed bench for cntry_req_sched with a simple
// signal-controller model and an expected-value queue.
module tb_cntry_req_sched;
  import sig_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cntry_req_sched_if bus();

  cntry_req_sched #(
    .CW        (29),
    .DEB_CYC   (4),
    .HWY_MIN   (20),
    .CNTRY_MIN (10),
    .CNTRY_MAX (50)
  ) dut (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Controller model: yellow lasts 3 cycles each way.
  typedef enum logic [1:0] {C_HG, C_HY, C_CG, C_CY} cst_t;
  cst_t       cs;
  logic [1:0] ccnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      cs   <= C_HG;
      ccnt <= 2'd0;
    end else begin
      case (cs)
        C_HG: if (bus.X) begin cs <= C_HY; ccnt <= 2'd0; end
        C_HY: if (ccnt == 2'd2) cs <= C_CG; else ccnt <= ccnt + 2'd1;
        C_CG: if (!bus.X) begin cs <= C_CY; ccnt <= 2'd0; end
        C_CY: if (ccnt == 2'd2) cs <= C_HG; else ccnt <= ccnt + 2'd1;
        default: cs <= C_HG;
      endcase
    end
  end

  always_comb begin
    bus.rgb_hwy   = LAMP_OFF;
    bus.rgb_cntry = LAMP_OFF;
    if (rst_n) begin
      case (cs)
        C_HG: begin bus.rgb_hwy = LAMP_GRN; bus.rgb_cntry = LAMP_RED; end
        C_HY: begin bus.rgb_hwy = LAMP_YEL; bus.rgb_cntry = LAMP_RED; end
        C_CG: begin bus.rgb_hwy = LAMP_RED; bus.rgb_cntry = LAMP_GRN; end
        default: begin bus.rgb_hwy = LAMP_RED; bus.rgb_cntry = LAMP_YEL; end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic wait_state(input string tag, input state_t s,
                            input int max);
    for (int i = 0; i < max; i++) begin
      if (dut.state == s) break;
      tick();
    end
    push(32'd1);
    chk(tag, {31'd0, dut.state == s});
  endtask

  initial begin
    int   n;
    logic bad;
    logic seen;
    rst_n       = 1'b0;
    bus.car_raw = 1'b0;
    bus.ped_btn = 1'b0;

    // Reset values
    push(32'd0); push(32'd0); push(32'd0); push(32'(S_HWY));
    repeat (3) tick();
    chk("rst_x", {31'd0, bus.X});
    chk("rst_ped", {31'd0, bus.ped_pending});
    chk("rst_deb", {31'd0, bus.car_deb});
    chk("rst_state", 32'(dut.state));
    rst_n = 1'b1;

    // 1: three-cycle glitch is filtered
    bus.car_raw = 1'b1;
    repeat (3) tick();
    bus.car_raw = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | bus.car_deb | bus.X;
    end
    push(32'd0);
    chk("glitch", {31'd0, seen});

    // 2: car from hwy-green cycle 5
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    bus.car_raw = 1'b1;
    push(32'd0);
    repeat (5) tick();
    chk("deb_early", {31'd0, bus.car_deb});
    push(32'd1); push(32'd10);
    tick();
    chk("deb_rise", {31'd0, bus.car_deb});
    chk("hwy_t_deb", 32'(dut.hwy_t));
    push(32'd0);
    repeat (10) tick();
    chk("x_before_min", {31'd0, bus.X});
    push(32'd1); push(32'd21);
    tick();
    chk("x_at_min", {31'd0, bus.X});
    chk("hwy_t_x", 32'(dut.hwy_t));

    // 3: car held through country max
    wait_state("wait_cntry3", S_CNTRY, 40);
    push(32'd0);
    chk("cntry_t_entry", 32'(dut.cntry_t));
    push(32'd1);
    repeat (50) tick();
    chk("x_hold_max", {31'd0, bus.X});
    push(32'd0); push(32'(S_REL));
    tick();
    chk("x_drop_max", {31'd0, bus.X});
    chk("state_rel", 32'(dut.state));
    bad = 1'b0;
    n = 0;
    while (bus.rgb_hwy != LAMP_GRN && n < 20) begin
      if (dut.state != S_REL || bus.X) bad = 1'b1;
      tick();
      n++;
    end
    push(32'd0);
    chk("rel_hold", {31'd0, bad});
    push(32'(S_HWY)); push(32'd0);
    tick();
    chk("back_hwy", 32'(dut.state));
    chk("hwy_t_clr", 32'(dut.hwy_t));

    // 4: car leaves at country cycle 3
    wait_state("wait_cntry4", S_CNTRY, 60);
    repeat (3) tick();
    bus.car_raw = 1'b0;
    push(32'd1);
    repeat (5) tick();
    chk("deb_hold", {31'd0, bus.car_deb});
    push(32'd0);
    tick();
    chk("deb_fall", {31'd0, bus.car_deb});
    push(32'd1);
    tick();
    chk("x_before_cmin", {31'd0, bus.X});
    push(32'd0);
    tick();
    chk("x_at_cmin", {31'd0, bus.X});

    // 5: pedestrian only
    wait_state("wait_hwy5", S_HWY, 30);
    push(32'd0);
    chk("hwy_t_entry5", 32'(dut.hwy_t));
    bus.ped_btn = 1'b1;
    push(32'd0);
    repeat (2) tick();
    bus.ped_btn = 1'b0;
    chk("ped_early", {31'd0, bus.ped_pending});
    push(32'd1);
    tick();
    chk("ped_set", {31'd0, bus.ped_pending});
    for (int i = 0; i < 40; i++) begin
      if (bus.X) break;
      tick();
    end
    push(32'd1); push(32'd21);
    chk("ped_x", {31'd0, bus.X});
    chk("ped_hwy_t", 32'(dut.hwy_t));
    wait_state("wait_cntry5", S_CNTRY, 20);
    push(32'd0);
    chk("ped_clr", {31'd0, bus.ped_pending});
    bus.ped_btn = 1'b1;
    repeat (2) tick();
    bus.ped_btn = 1'b0;
    push(32'd1); push(32'd0);
    repeat (8) tick();
    chk("ped_x_hold", {31'd0, bus.X});
    chk("ped_in_cntry", {31'd0, bus.ped_pending});
    push(32'd0);
    tick();
    chk("ped_x_drop", {31'd0, bus.X});

    // 6: reset during country green
    bus.car_raw = 1'b1;
    wait_state("wait_cntry6", S_CNTRY, 80);
    repeat (5) tick();
    rst_n = 1'b0;
    push(32'd0); push(32'd0); push(32'd0);
    push(32'(S_HWY)); push(32'd0); push(32'd0);
    tick();
    chk("mid_rst_x", {31'd0, bus.X});
    chk("mid_rst_ped", {31'd0, bus.ped_pending});
    chk("mid_rst_deb", {31'd0, bus.car_deb});
    chk("mid_rst_state", 32'(dut.state));
    chk("mid_rst_hwy_t", 32'(dut.hwy_t));
    chk("mid_rst_cntry_t", 32'(dut.cntry_t));
    bus.car_raw = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
